// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } nsa_state_t;

endpackage

// File: rtl/fourbit_FA_str.sv
// Structural 4-bit ripple-carry adder built from per-bit full-adder equations.
// Combinational, no backpressure.
module fourbit_FA_str (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two W-bit operands one nibble per cycle through a single 4-bit adder; NSA_OVERFLOW_EN adds ovf.
// Latency: out_valid NIBBLES cycles after the accepting edge; one operation per NIBBLES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
`ifdef NSA_OVERFLOW_EN
  output logic         ovf,
`endif
  output logic         busy
);

  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  nsa_state_t state_q, state_d;

  logic [IDX_W-1:0]    idx_q;
  logic [W-1:0]        a_q, b_q;
  logic                carry_q;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_c;
  logic                accept, run_step, last_step;

  assign nib_a = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign nib_b = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];

  fourbit_FA_str u_fa (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    run_step  = 1'b0;
    last_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy     = 1'b1;
        run_step = 1'b1;
        if (idx_q == LAST_IDX) begin
          last_step = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // sum/cout stay put in IDLE and DONE; only acceptance or a RUN step touches them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf     <= 1'b0;
`endif
    end else if (run_step) begin
      sum[NIBBLE_W*int'(idx_q) +: NIBBLE_W] <= nib_s;
      carry_q <= nib_c;
      idx_q   <= last_step ? '0 : idx_q + 1'b1;
      if (last_step) begin
        cout <= nib_c;
`ifdef NSA_OVERFLOW_EN
        // the final nibble's top bit is the result sign bit
        ovf  <= (a_q[W-1] == b_q[W-1]) && (nib_s[NIBBLE_W-1] != a_q[W-1]);
`endif
      end
    end
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-006 SHALL have port a, input, W bits: addend A, unsigned or two's complement.
REQ-007 SHALL have port b, input, W bits: addend B.
REQ-008 SHALL have port cin, input, 1 bit: carry into nibble 0.
REQ-009 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port sum, output, W bits: registered result.
REQ-012 SHALL have port cout, output, 1 bit: registered carry out of the top nibble.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready high only in IDLE; a handshake is in_valid && in_ready at a rising edge.
REQ-016 On handshake, SHALL latch a, b, carry register <= cin, nibble index <= 0, clear sum, and go to RUN.
REQ-017 In RUN, SHALL present nibble[idx] of the latched a and b, plus the carry register, to one 4-bit ripple adder every cycle; at the edge, write S into sum nibble idx, set carry <= Cout, and increment idx.
REQ-018 SHALL leave RUN for DONE at the edge that processes idx == NIBBLES-1, and load cout from the final carry at that edge.
REQ-019 SHALL assert out_valid after exactly NIBBLES rising edges following the accepting edge (latency NIBBLES cycles).
REQ-020 In DONE, SHALL hold out_valid, sum and cout stable until out_valid && out_ready, then return to IDLE at that edge.
REQ-021 SHALL sustain at most one operation per NIBBLES+2 cycles; there is no IDLE bypass and no overlap.
REQ-022 SHALL ignore in_valid in RUN and DONE; a changing a, b or cin after acceptance SHALL not affect the result.
REQ-023 SHALL produce a modulo-2^W sum, with cout as bit W of a+b+cin (for example, all-ones plus 1 gives sum 0 and cout 1).
REQ-024 SHALL keep sum and cout at their last values in IDLE until the next acceptance clears them.

Reset
REQ-025 While rst_n is low, SHALL force IDLE, idx 0, carry 0, sum 0, cout 0, out_valid 0 and busy 0; in_ready SHALL be 1 once the FSM is in IDLE.
REQ-026 Reset asserted in RUN or DONE SHALL discard the operation and give no partial out_valid.
REQ-027 Reset deassertion SHALL need no synchronizing cycles inside the block; the first handshake is possible at the first edge after deassertion.

Configuration
REQ-028 With macro NSA_OVERFLOW_EN defined, SHALL add output ovf, 1 bit: signed overflow of the registered result.
REQ-029 ovf SHALL equal (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), registered with cout, reset to 0, and held with sum.
REQ-030 Without NSA_OVERFLOW_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL take the state encoding typedef and constant NIBBLE_W = 4 from shared package nsa_pkg.
REQ-032 SHALL instantiate the team's existing fourbit_FA_str as the single adder sub-module; no other sub-modules.

Verification
REQ-033 Bench SHALL cover: NIBBLES=4, a=16'h1234, b=16'h0FCD, cin=0 -> after 4 cycles out_valid=1, sum=16'h2201, cout=0.
REQ-034 Bench SHALL cover: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1 (full carry ripple through all nibbles).
REQ-035 Bench SHALL cover: out_ready held low for 5 cycles in DONE -> sum, cout and out_valid stable, in_ready=0, and a new in_valid is ignored.
REQ-036 Bench SHALL cover: rst_n pulsed low at RUN idx=2 -> all outputs at reset values immediately, in_ready=1, and no out_valid afterward.
REQ-037 Bench SHALL cover: with NSA_OVERFLOW_EN, a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, ovf=1, cout=0.
REQ-038 Bench SHALL cover: back-to-back operations with in_valid and out_ready held high -> a new acceptance every NIBBLES+2 cycles, and every result matches a+b+cin.
